// File: rtl/pixel_source_fifo.sv
// rtl/pixel_source_fifo.sv - per-lane pixel FIFO with fill report and req/ack grant handshake
module pixel_source_fifo #(
    parameter int LENGTH      = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int DEPTH       = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_valid,
    input  logic [PIXEL_WIDTH-1:0] wr_pix,
    output logic                   wr_ready,
    output logic [LENGTH-1:0]      fill,
    input  logic                   req,
    output logic                   ack,
    output logic [PIXEL_WIDTH-1:0] pix_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state;
    logic [PIXEL_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic                   push;
    logic                   pop;

    // A pop only starts from IDLE, so each request level yields at most one pixel
    assign wr_ready = (count != FULL_COUNT);
    assign push     = wr_valid && wr_ready;
    assign pop      = (state == IDLE) && req && (count != '0);
    assign fill     = LENGTH'(count);

    // Storage array is intentionally left unreset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_pix;
        end
    end

    // Pointer and occupancy bookkeeping; a write and a pop in the same edge cancel in count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Grant FSM: IDLE pops the head, GRANT pulses ack, RELEASE waits for req to drop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ack     <= 1'b0;
            pix_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= 1'b0;
                    if (pop) begin
                        pix_out <= mem[rd_ptr];
                        ack     <= 1'b1;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    ack   <= 1'b0;
                    state <= RELEASE;
                end
                RELEASE: begin
                    ack <= 1'b0;
                    if (!req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    ack   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pixel_source_fifo.md
# pixel_source_fifo

Per-lane pixel source that feeds one input of the contention tree. Buffers pixels produced by a rasterizer lane, publishes its occupancy on `fill` so the tree can pick the fullest lane, and answers the tree's `req` with a single-cycle `ack` plus the head pixel on `pix_out`. Four instances sit in front of the contention tree, one per `pix_in_n`/`fill_n`/`req_n`/`ack_n` group.

## Interface
- `LENGTH`, 8: width of `fill`; must satisfy DEPTH <= 2**LENGTH-1.
- `PIXEL_WIDTH`, 8: pixel word width.
- `DEPTH`, 16: FIFO capacity in pixels, power of two, >= 2.

- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: rasterizer presents a pixel this cycle.
- `wr_pix` in PIXEL_WIDTH: pixel to enqueue.
- `wr_ready` out 1: FIFO can accept a pixel (not full).
- `fill` out LENGTH: current occupancy, zero-extended.
- `req` in 1: contention tree requests one pixel from this lane (level).
- `ack` out 1: one-cycle pulse; `pix_out` valid while high.
- `pix_out` out PIXEL_WIDTH: last granted pixel, held until the next grant.

## Operation
- Storage: DEPTH-entry circular buffer, write pointer, read pointer (log2(DEPTH) bits, natural wrap), count register (log2(DEPTH)+1 bits); `fill` = count.
- Enqueue: write accepted at an edge when `wr_valid && wr_ready`; `wr_ready` = (count != DEPTH), combinational from count. `wr_valid` while full is ignored, no state change.
- Grant FSM, states IDLE, GRANT, RELEASE:
  - IDLE: `ack`=0. At an edge with `req`=1 and count != 0: `pix_out` <= buffer[rd_ptr], rd_ptr++, go GRANT. `req`=1 with count=0: stay IDLE, no ack (request remains pending until data arrives or `req` drops).
  - GRANT: `ack`=1 for exactly this one cycle. Next edge -> RELEASE unconditionally.
  - RELEASE: `ack`=0. Go IDLE at the first edge where `req`=0; otherwise stay. Guarantees one pixel per request pulse.
- Count update per edge: +1 on accepted write, -1 on pop (IDLE->GRANT), unchanged when both occur.
- No bypass: a pixel written at edge N is poppable at edge N+1 at the earliest.
- `pix_out` changes only on the IDLE->GRANT edge; stable through GRANT, RELEASE and IDLE.

## Timing
- Reset (`reset_n`=0, asynchronous): state IDLE, `ack`=0, `pix_out`=0, pointers 0, count 0, so `fill`=0 and `wr_ready`=1. Buffer contents are not reset.
- Reset asserted mid-grant: `ack` drops immediately; the in-flight pixel is lost; no ack after release until a fresh `req` in IDLE.
- Request latency: `req` sampled high at edge k with count>0 -> `ack`=1 and valid `pix_out` during cycle k+1; `fill` reflects the pop in cycle k+1.
- Minimum grant spacing: 3 cycles (IDLE->GRANT->RELEASE->IDLE) if `req` drops during GRANT.
- Full boundary: count=DEPTH -> `wr_ready`=0 in the same cycle; a pop at edge k restores `wr_ready`=1 in cycle k+1. Simultaneous write and pop while full is not possible (write is blocked), so count goes DEPTH -> DEPTH-1.
- Empty boundary: simultaneous write and pending `req` with count=0 at edge k: write accepted, no pop; pop occurs at edge k+1, ack in cycle k+2.
- Pointer wrap: after DEPTH writes, wr_ptr returns to 0; ordering stays strictly FIFO across wrap.

## Test plan
- Reset: hold `reset_n`=0 with `wr_valid`=1 and `req`=1 -> `ack`=0, `pix_out`=0, `fill`=0, `wr_ready`=1; release -> no ack until a pixel is written.
- Basic grant: write 0x11, 0x22; pulse `req` for 2 cycles -> `ack` one cycle after req sampled, `pix_out`=0x11, `fill` 2->1; second req pulse -> `pix_out`=0x22, `fill`=0.
- Held request: keep `req`=1 for 10 cycles with 3 pixels queued -> exactly one `ack` pulse, `fill`=2; drop and re-raise `req` -> second ack.
- Full/wrap (DEPTH=16): write 0x00..0x0F -> `fill`=16, `wr_ready`=0, write of 0xFF ignored; pop one, write 0x10 -> subsequent 16 grants return 0x01..0x10 in order.
- Empty pending request: `req`=1 with `fill`=0 for 5 cycles -> no ack; write 0xA5 at edge k -> `ack`=1, `pix_out`=0xA5 in cycle k+2.
- Simultaneous write and pop at `fill`=4 -> `fill` stays 4; async reset asserted during GRANT -> `ack` falls without waiting for the next edge, `fill`=0.
